// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states,
// latency counter width and the latched request record.
package dmem_pkg;
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/dmem_if.sv
// MEM-stage load/store bus: request and response valid/ready channels.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_align.sv
// Byte-lane steering for stores and sign/zero extension for loads.
// Purely combinational; size legality beyond alignment is judged by the caller.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic        misalign,
  output logic [31:0] rdata_ext
);
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] rshift;

  assign rshift = rword >> {addr_lo, 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be        = 4'b0000;
    wword     = wdata;
    misalign  = 1'b0;
    rdata_ext = 32'h0;
    case (size)
      SZ_B, SZ_BU: begin
        be        = 4'b0001 << addr_lo;
        wword     = {4{wdata[7:0]}};
        rdata_ext = (size == SZ_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      end
      SZ_H, SZ_HU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword     = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
        rdata_ext = (size == SZ_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
      end
      SZ_W: begin
        be        = 4'b1111;
        misalign  = |addr_lo;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory behind the MEM stage: one request at a time,
// fixed LATENCY from accept to response, registered response held until taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  req_t               lat;
  logic [31:0]        mem [DEPTH_WORDS];
  logic               resp_valid_q, resp_err_q;
  logic [31:0]        resp_rdata_q;

  logic [3:0]  be;
  logic [31:0] wword, rword, rext;
  logic        misalign, range_err, size_err, err_c, do_access;
  logic [IDX_W-1:0] idx;

  assign idx       = lat.addr[IDX_W+1:2];
  assign rword     = mem[idx];
  assign range_err = ({2'b00, lat.addr[31:2]} >= 32'(DEPTH_WORDS));
  assign err_c     = misalign | range_err | size_err;
  assign do_access = (state == WAIT) && (cnt == '0);

  always_comb begin
    size_err = 1'b0;
    case (lat.size)
      SZ_B, SZ_H, SZ_W: size_err = 1'b0;
      SZ_BU, SZ_HU:     size_err = lat.write;  // unsigned variants are load-only
      default:          size_err = 1'b1;
    endcase
  end

  dmem_align u_align (
    .addr_lo   (lat.addr[1:0]),
    .size      (lat.size),
    .wdata     (lat.wdata),
    .rword     (rword),
    .be        (be),
    .wword     (wword),
    .misalign  (misalign),
    .rdata_ext (rext)
  );

  // Array is never reset; a store abandoned by reset never reaches it.
  always_ff @(posedge clk) begin
    if (!reset && do_access && lat.write && !err_c) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          lat   <= '{write: bus.req_write, size: bus.req_size,
                     addr: bus.req_addr, wdata: bus.req_wdata};
          cnt   <= CNT_W'(LATENCY - 1);
          state <= WAIT;
        end
        WAIT: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= err_c;
          resp_rdata_q <= (err_c || lat.write) ? 32'h0 : rext;
          state        <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          resp_valid_q <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE) && !reset;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at default parameters.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_if bus ();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive one request, wait (bounded) for its response, let it complete with resp_ready=1.
  task automatic txn(input logic w, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic e,
                     output int lat);
    int n;
    @(negedge clk);
    bus.req_write = w; bus.req_size = sz; bus.req_addr = a; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = bus.resp_rdata;
    e  = bus.resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err got %b want 0", bus.resp_err); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL release_req_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 3'b010, 32'h10, 32'h8055AA11, rd, e, lat);
    n_cmp++; if (e !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sw_resp got err=%b rdata=%h want err=0 rdata=0", e, rd); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency got %0d want 2", lat); end
    txn(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    n_cmp++; if (e !== 1'b0 || rd !== 32'h8055AA11) begin n_bad++; $display("FAIL lw_resp got err=%b rdata=%h want err=0 rdata=8055aa11", e, rd); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency got %0d want 2", lat); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic e; int lat;
    logic [2:0]  sz  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8055, 32'h0000AA11};
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, sz[i], ad[i], 32'h0, rd, e, lat);
      n_cmp++;
      if (e !== 1'b0 || rd !== exp[i]) begin
        n_bad++; $display("FAIL subword_load_%0d got err=%b rdata=%h want err=0 rdata=%h", i, e, rd, exp[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 3'b000, 32'h11, 32'h123456FF, rd, e, lat);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL sb_err got %b want 0", e); end
    txn(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'h8055FF11) begin n_bad++; $display("FAIL sb_readback got %h want 8055ff11", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    txn(1'b0, 3'b010, 32'h12, 32'h0, rd, e, lat);
    n_cmp++; if (e !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lw_misalign got err=%b rdata=%h want err=1 rdata=0", e, rd); end
    txn(1'b1, 3'b001, 32'h11, 32'hCAFEBABE, rd, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL sh_misalign got err=%b want 1", e); end
    txn(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    n_cmp++; if (rd !== 32'h8055FF11) begin n_bad++; $display("FAIL sh_misalign_nowrite got %h want 8055ff11", rd); end
    txn(1'b0, 3'b010, 32'h400, 32'h0, rd, e, lat);
    n_cmp++; if (e !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lw_range got err=%b rdata=%h want err=1 rdata=0", e, rd); end
    txn(1'b0, 3'b011, 32'h10, 32'h0, rd, e, lat);
    n_cmp++; if (e !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL bad_size got err=%b rdata=%h want err=1 rdata=0", e, rd); end
    txn(1'b1, 3'b100, 32'h10, 32'h0, rd, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL store_bu got err=%b want 1", e); end
  endtask

  task automatic test_backpressure();
    int n;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    bus.req_write = 1'b0; bus.req_size = 3'b010; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    // Keep a different request on the bus; it must be ignored.
    bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h0BADF00D;
    n = 0;
    while (!bus.resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL bp_latency got %0d want 2", n); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h8055FF11 ||
          bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold_%0d got valid=%b rdata=%h err=%b ready=%b want 1/8055ff11/0/0",
                 i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat;
    logic seen;
    txn(1'b1, 3'b010, 32'h20, 32'h01020304, rd, e, lat);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL sw20_err got %b want 0", e); end
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 3'b010; bus.req_addr = 32'h20;
    bus.req_wdata = 32'hDEADBEEF; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_mid_no_resp got resp_valid=1 want 0"); end
    txn(1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
    n_cmp++; if (e !== 1'b0 || rd !== 32'h01020304) begin n_bad++; $display("FAIL reset_mid_readback got err=%b rdata=%h want err=0 rdata=01020304", e, rd); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    test_reset();
    test_word();
    test_subword();
    test_byte_store();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core. It is the memory-side end of the MEM-stage load/store interface. It accepts one load or store request at a time over a valid/ready handshake and performs the access after a fixed, parameterised latency. It returns a registered response carrying sign/zero-extended load data or an error flag. It replaces the single-cycle data memory behind the MEM stage so that the MEM/WB path can be exercised with multi-cycle memory.

## Interface
Parameters:
- DEPTH_WORDS, 256: storage depth in 32-bit words; byte address range is 0 to 4*DEPTH_WORDS-1.
- LATENCY, 2: number of cycles from the request-accept edge to resp_valid rising; legal range 1 to 15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; 1 only in IDLE and only while reset is low.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low-order bits are used for B and H.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range, or illegal-size request.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: when req_valid && req_ready, latch write, size, addr and wdata, load cnt = LATENCY-1, and go to WAIT.
- WAIT: if cnt != 0, decrement it. If cnt == 0, perform the access on that edge, register resp_rdata and resp_err, set resp_valid, and go to RESP.
- RESP: hold resp_valid, resp_rdata and resp_err stable until resp_ready is high. On that edge, clear resp_valid and go to IDLE.
- req_valid is ignored outside IDLE. There is no back-to-back accept.
- Error detection (any condition sets err=1, no array write, rdata=0):
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
  - req_size in {011, 110, 111}.
  - store with size in {100, 101}.
- Store lanes:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Lanes not written keep their previous contents.
- Load extraction:
  - Select the byte or half at addr[1:0] or addr[1].
  - B and H sign-extend from bit 7 or bit 15.
  - BU and HU zero-extend.
  - W returns the whole word.
- Store response: resp_valid=1, resp_rdata=0, resp_err reflects the error check.
- Reset:
  - Values while reset is asserted and on the first edge after it: state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0.
  - Array contents are not cleared.
- Reset mid-operation: the transaction is abandoned. A store still in WAIT is never written, and no response is produced.

## Timing
- Accept on edge N. The array is accessed and resp_valid rises on edge N+LATENCY.
- With resp_ready held at 1, the response completes on edge N+LATENCY+1. The next accept is no earlier than edge N+LATENCY+2.
- Peak throughput is one transaction per LATENCY+2 cycles.
- resp_rdata and resp_err are registered and change only on the edge that sets resp_valid, or on reset.
- req_ready is combinational from the state and reset only. It never depends on req_valid.
- A load immediately after a store to the same word returns the new data, because the write completes before the next accept.

## Structure
- Shared package dmem_pkg contains:
  - the size code localparams (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU);
  - the state enum (IDLE, WAIT, RESP);
  - the counter width constant (4).
- One sub-module, dmem_align, is combinational. It takes addr[1:0], size and wdata, and produces the 4-bit byte-write mask, the lane-steered write word, the misalignment flag, and the extended load data from a raw word.
- dmem_responder holds the FSM, the latency counter, the request latch, the array, and the response registers.

## Test plan
All scenarios use the defaults (LATENCY=2, DEPTH_WORDS=256).
- **Reset:** hold reset 2 cycles. Require req_ready=0, resp_valid=0, resp_rdata=0 and resp_err=0. After release, require req_ready=1.
- **Word store/load:** SW addr 0x10, wdata 0x8055AA11, then LW 0x10. Require rdata=0x8055AA11 and err=0, with resp_valid rising exactly 2 edges after each accept.
- **Sub-word loads** after the store above:
  - LB 0x13 returns 0xFFFFFF80.
  - LBU 0x13 returns 0x00000080.
  - LH 0x12 returns 0xFFFF8055.
  - LHU 0x10 returns 0x0000AA11.
- **Byte store:** SB 0x11 with wdata 0x123456FF, then LW 0x10. Require 0x8055FF11.
- **Errors:**
  - LW 0x12 gives err=1, rdata=0.
  - SH 0x11 gives err=1, and a subsequent LW 0x10 is unchanged.
  - LW 0x400 gives err=1.
  - size 011 gives err=1.
- **Backpressure and reset:**
  - Hold resp_ready=0 for 5 cycles. Require resp_valid, rdata and err to stay stable and req_ready=0 with req_valid=1 ignored.
  - Assert reset during WAIT of SW 0x20 with wdata 0xDEADBEEF. Require no response, and a subsequent LW 0x20 returns the prior contents.
